// File: rtl/mm_pkg.sv
// Shared widths, drain FSM states and FIFO entry layout for the matrix result drain.
// MAT_RESULT_DRAIN_PARITY_EN adds a parity bit to every FIFO entry.
package mm_pkg;

  localparam int unsigned RES_W = 32;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic [RES_W-1:0] data;
    logic [SEL_W-1:0] idx;
    logic             last;
`ifdef MAT_RESULT_DRAIN_PARITY_EN
    logic             parity;
`endif
  } res_entry_t;

endpackage

// File: rtl/mat_result_fifo.sv
// Synchronous FIFO of result entries; the head entry is presented directly to the output.
// A flush empties it in one cycle and overrides any push or pop in that cycle.
module mat_result_fifo
  import mm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  res_entry_t             push_entry,
  input  logic                   pop,
  output res_entry_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  res_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head      = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mat_result_drain.sv
// Sweeps the multiplier result mux once per done assertion and streams the elements out through a FIFO.
// Define MAT_RESULT_DRAIN_PARITY_EN to add the m_parity output (XOR of m_data).
module mat_result_drain
  import mm_pkg::*;
#(
  parameter int unsigned N_ELEM     = 9,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done,
  output logic [SEL_W-1:0] out_sel,
  input  logic [RES_W-1:0] res_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [RES_W-1:0] m_data,
  output logic [SEL_W-1:0] m_idx,
  output logic             m_last,
`ifdef MAT_RESULT_DRAIN_PARITY_EN
  output logic             m_parity,
`endif
  output logic             busy,
  output logic             abort
);

  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_ELEM - 1);

  drain_state_t     state;
  drain_state_t     state_next;
  logic             issue_c;
  logic             abort_c;
  logic             credit_ok;
  logic             inflight_v;
  logic [SEL_W-1:0] inflight_idx;
  logic             push_c;
  logic             pop_c;
  res_entry_t       push_entry;
  res_entry_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_occ;

  // Only issue when the FIFO can absorb every result already requested
  assign credit_ok = !fifo_full && ((fifo_occ + CNT_W'(inflight_v)) < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (done) state_next = ST_SWEEP;
      ST_SWEEP: begin
        if (!done) begin
          state_next = ST_IDLE;
        end else if (issue_c && (out_sel == LAST_IDX)) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!done) begin
          state_next = ST_IDLE;
        end else if (fifo_empty && !inflight_v) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD:  if (!done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_c = 1'b0;
    abort_c = 1'b0;
    case (state)
      ST_SWEEP: begin
        abort_c = !done;
        issue_c = done && credit_ok;
      end
      ST_FLUSH: abort_c = !done;
      default:  ;
    endcase
  end

  // Issue index, single in-flight capture slot and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sel      <= '0;
      inflight_v   <= 1'b0;
      inflight_idx <= '0;
      busy         <= 1'b0;
      abort        <= 1'b0;
    end else begin
      abort      <= abort_c;
      busy       <= (state_next == ST_SWEEP) || (state_next == ST_FLUSH);
      inflight_v <= issue_c;
      if (issue_c) begin
        inflight_idx <= out_sel;
      end
      if (state == ST_IDLE) begin
        out_sel <= '0;
      end else if (issue_c && (out_sel != LAST_IDX)) begin
        out_sel <= out_sel + SEL_W'(1);
      end
    end
  end

  assign push_c = inflight_v && !abort_c;
  assign pop_c  = m_valid && m_ready;

  always_comb begin
    push_entry        = '0;
    push_entry.data   = res_in;
    push_entry.idx    = inflight_idx;
    push_entry.last   = (inflight_idx == LAST_IDX);
`ifdef MAT_RESULT_DRAIN_PARITY_EN
    push_entry.parity = ^res_in;
`endif
  end

  mat_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort_c),
    .push      (push_c),
    .push_entry(push_entry),
    .pop       (pop_c),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign m_valid  = !fifo_empty;
  assign m_data   = head.data;
  assign m_idx    = head.idx;
  assign m_last   = head.last;
`ifdef MAT_RESULT_DRAIN_PARITY_EN
  assign m_parity = head.parity;
`endif

endmodule

// File: tb/tb_mat_result_drain.sv
// Directed frames for mat_result_drain checked against an expected-word list built from frame contents.
// Build with MAT_RESULT_DRAIN_PARITY_EN defined to also check m_parity.
module tb_mat_result_drain;
  import mm_pkg::*;

  localparam int unsigned N = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        done;
  logic [3:0]  out_sel;
  logic [31:0] res_in = '0;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_idx;
  logic        m_last;
`ifdef MAT_RESULT_DRAIN_PARITY_EN
  logic        m_parity;
`endif
  logic        busy;
  logic        abort;

  mat_result_drain #(
    .N_ELEM    (N),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .done    (done),
    .out_sel (out_sel),
    .res_in  (res_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last),
`ifdef MAT_RESULT_DRAIN_PARITY_EN
    .m_parity(m_parity),
`endif
    .busy    (busy),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  // Registered result mux standing in for the multiplier
  logic [31:0] base = '0;
  always @(posedge clk) res_in <= base + 32'(out_sel);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Expected words, appended by the stimulus; consumed by the compare process
  logic [31:0] exp_d [256];
  logic [3:0]  exp_i [256];
  logic        exp_l [256];
  int          exp_wr = 0;
  int          flush_gen = 0;

  task automatic load_frame(input logic [31:0] b);
    for (int i = 0; i < int'(N); i++) begin
      exp_d[exp_wr] = b + 32'(i);
      exp_i[exp_wr] = 4'(i);
      exp_l[exp_wr] = (i == int'(N) - 1);
      exp_wr++;
    end
  endtask

  // Received words, recorded only by the compare process
  logic [31:0] rx_data [128];
  logic [3:0]  rx_idx  [128];
  logic        rx_last [128];
  logic        rx_par  [128];
  int          rx_cyc  [128];
  int          rx_cnt = 0;
  int          exp_rd = 0;
  int          seen_gen = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [3:0]  hold_i;
  logic        hold_l;

  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (flush_gen != seen_gen) begin
        exp_rd   = exp_wr;
        seen_gen = flush_gen;
      end
      if (hold_v && m_valid) begin
        check("stall_data", m_data, hold_d);
        check("stall_idx", 32'(m_idx), 32'(hold_i));
        check("stall_last", 32'(m_last), 32'(hold_l));
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_rd >= exp_wr) begin
          errors++;
          $display("FAIL unexpected_word: got idx %0d data 0x%08h, required no word", m_idx, m_data);
        end else begin
          check("word_data", m_data, exp_d[exp_rd]);
          check("word_idx", 32'(m_idx), 32'(exp_i[exp_rd]));
          check("word_last", 32'(m_last), 32'(exp_l[exp_rd]));
`ifdef MAT_RESULT_DRAIN_PARITY_EN
          check("word_parity", 32'(m_parity), 32'(^exp_d[exp_rd]));
          rx_par[rx_cnt % 128] = m_parity;
`else
          rx_par[rx_cnt % 128] = ^m_data;
`endif
          rx_data[rx_cnt % 128] = m_data;
          rx_idx[rx_cnt % 128]  = m_idx;
          rx_last[rx_cnt % 128] = m_last;
          rx_cyc[rx_cnt % 128]  = cyc;
          rx_cnt++;
          exp_rd++;
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_i = m_idx;
      hold_l = m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (rx_cnt < target && n < budget);
    checks++;
    if (rx_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words, required %0d", name, rx_cnt, target);
    end
  endtask

  int rb;
  int c0;

  initial begin
    reset = 1'b1; done = 1'b0; m_ready = 1'b0;
    tick(3);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_idx", 32'(m_idx), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    reset = 1'b0;
    tick(2);

    // Full-rate frame, then done held high well past the end of the frame
    base = 32'h100; load_frame(base); rb = rx_cnt;
    m_ready = 1'b1; done = 1'b1; c0 = cyc;
    tick(1);
    check("f1_busy", 32'(busy), 32'd1);
    wait_words(rb + 9, 40, "f1");
    check("f1_latency", 32'(rx_cyc[rb % 128] - c0), 32'd3);
    check("f1_back_to_back", 32'(rx_cyc[(rb + 8) % 128] - rx_cyc[rb % 128]), 32'd8);
    check("f1_first_data", rx_data[rb % 128], 32'h100);
    check("f1_last_data", rx_data[(rb + 8) % 128], 32'h108);
    check("f1_last_idx", 32'(rx_idx[(rb + 8) % 128]), 32'd8);
    check("f1_last_flag", 32'(rx_last[(rb + 8) % 128]), 32'd1);
    check("f1_not_last", 32'(rx_last[(rb + 7) % 128]), 32'd0);
    tick(50);
    check("hold_word_count", 32'(rx_cnt - rb), 32'd9);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_m_valid", 32'(m_valid), 32'd0);

    // Second frame after done drops and rises, with m_ready toggling every cycle
    done = 1'b0;
    tick(1);
    base = 32'h200; load_frame(base); rb = rx_cnt;
    done = 1'b1;
    for (int n = 0; n < 60 && rx_cnt < rb + 9; n++) begin
      m_ready = ~m_ready;
      tick(1);
    end
    m_ready = 1'b1;
    tick(5);
    check("f2_word_count", 32'(rx_cnt - rb), 32'd9);
    check("f2_mid_data", rx_data[(rb + 4) % 128], 32'h204);

    // Downstream stalled for 10 cycles: issue must stop with 4 results buffered
    done = 1'b0; m_ready = 1'b0;
    tick(1);
    base = 32'h300; load_frame(base); rb = rx_cnt;
    done = 1'b1;
    tick(10);
    check("stall_out_sel", 32'(out_sel), 32'd4);
    check("stall_no_words", 32'(rx_cnt - rb), 32'd0);
    check("stall_m_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    wait_words(rb + 9, 40, "f3");
    check("f3_first_data", rx_data[rb % 128], 32'h300);
    check("f3_last_data", rx_data[(rb + 8) % 128], 32'h308);

    // done drops after five words: frame abandoned
    done = 1'b0;
    tick(1);
    base = 32'h400; load_frame(base); rb = rx_cnt;
    done = 1'b1;
    wait_words(rb + 5, 40, "f4");
    done = 1'b0; m_ready = 1'b0; flush_gen++;
    tick(1);
    check("abort_pulse", 32'(abort), 32'd1);
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick(1);
    check("abort_once", 32'(abort), 32'd0);
    check("abort_word_count", 32'(rx_cnt - rb), 32'd5);

    // Fresh frame straight out of IDLE; data values 3 and 7 exercise both parity values
    base = 32'h0; load_frame(base); rb = rx_cnt;
    m_ready = 1'b1; done = 1'b1; c0 = cyc;
    wait_words(rb + 9, 40, "f5");
    check("f5_latency", 32'(rx_cyc[rb % 128] - c0), 32'd3);
    check("f5_data7", rx_data[(rb + 7) % 128], 32'h7);
    check("f5_parity_of_7", 32'(rx_par[(rb + 7) % 128]), 32'd1);
    check("f5_parity_of_3", 32'(rx_par[(rb + 3) % 128]), 32'd0);

    // Reset in the middle of a sweep with words buffered
    done = 1'b0; m_ready = 1'b0;
    tick(1);
    base = 32'h500; load_frame(base);
    done = 1'b1;
    tick(4);
    check("presweep_m_valid", 32'(m_valid), 32'd1);
    reset = 1'b1; done = 1'b0; flush_gen++;
    tick(1);
    check("mid_rst_out_sel", 32'(out_sel), 32'd0);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_data", m_data, 32'd0);
    check("mid_rst_m_idx", 32'(m_idx), 32'd0);
    check("mid_rst_m_last", 32'(m_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_abort", 32'(abort), 32'd0);
    reset = 1'b0; m_ready = 1'b1;
    tick(10);
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_result_drain.md
MAT_RESULT_DRAIN -- requirements
Module: mat_result_drain

Interface
REQ-001 Parameter N_ELEM, default 9: result elements per frame; legal range 1..16.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer entries; power of two, at least 2.
REQ-003 Port clk, input, 1: the single clock; all logic on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port done, input, 1: multiplier results are stable and readable while high.
REQ-006 Port out_sel, output, 4: element index driven to the multiplier's result mux.
REQ-007 Port res_in, input, 32: multiplier registered result; carries element out_sel one cycle after out_sel is driven.
REQ-008 Port m_valid, output, 1: output word valid.
REQ-009 Port m_ready, input, 1: downstream accepts the word.
REQ-010 Port m_data, output, 32: result word.
REQ-011 Port m_idx, output, 4: element index of m_data.
REQ-012 Port m_last, output, 1: high with the element N_ELEM-1 word.
REQ-013 Port busy, output, 1: high in SWEEP or FLUSH.
REQ-014 Port abort, output, 1: one-cycle pulse when a frame is abandoned.

Function
REQ-015 FSM states: IDLE, SWEEP, FLUSH, HOLD.
REQ-016 IDLE goes to SWEEP on done=1; the issue index clears to 0.
REQ-017 In SWEEP, one index issues per cycle on out_sel, only if FIFO occupancy plus in-flight count is below FIFO_DEPTH; otherwise out_sel holds and the cycle does not issue.
REQ-018 The res_in sample for an issued index is captured into the FIFO exactly one cycle after issue, tagged with that index.
REQ-019 After index N_ELEM-1 issues, SWEEP goes to FLUSH.
REQ-020 FLUSH goes to HOLD when the FIFO is empty and nothing is in flight.
REQ-021 HOLD goes to IDLE only when done=0; this gives exactly one frame per done assertion.
REQ-022 The output is a FIFO head: m_valid=!empty; a word transfers on m_valid&&m_ready; m_data, m_idx and m_last hold stable while m_valid=1 and m_ready=0.
REQ-023 Push and pop in the same cycle on a full FIFO are legal; occupancy is unchanged.
REQ-024 If done falls in SWEEP or FLUSH: pulse abort, flush the FIFO, cancel in-flight captures, go to IDLE next cycle.
REQ-025 Best-case latency: done rise to first m_valid is 3 cycles; with m_ready=1, N_ELEM words follow on consecutive cycles.
REQ-026 Pointer and index counters wrap modulo their width; the index never exceeds N_ELEM-1.

Reset
REQ-027 On reset: state IDLE, out_sel=0, FIFO empty, m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, abort=0, in-flight cleared.
REQ-028 Reset in any state takes priority over every other event, including done and m_ready.

Configuration
REQ-029 Macro MAT_RESULT_DRAIN_PARITY_EN defined: an extra output m_parity (1 bit) carries the even parity (XOR) of m_data, stored per FIFO entry, reset value 0.
REQ-030 MAT_RESULT_DRAIN_PARITY_EN undefined: no m_parity port and no parity storage; all other behaviour is identical.

Structure
REQ-031 Package mm_pkg holds RES_W=32, SEL_W=4, the drain state enum, and the FIFO entry struct {data, idx, last[, parity]}.
REQ-032 Sub-module mat_result_fifo is a synchronous FIFO of FIFO_DEPTH entries with full, empty and occupancy outputs, instanced once.

Verification
REQ-033 Scenario: res_in=0x100+out_sel (registered), done=1, m_ready=1 -> nine words 0x100..0x108, m_idx 0..8, m_last only on idx 8, first m_valid at done+3.
REQ-034 Scenario: m_ready=0 for 10 cycles after done -> out_sel stalls at 4 (4 entries buffered, none lost); then m_ready=1 -> all 9 words in order.
REQ-035 Scenario: m_ready toggling 1/0 every cycle -> 9 words in order, no duplicates, m_data stable during stalls.
REQ-036 Scenario: done held high 50 cycles after the frame -> exactly 9 words, state HOLD; done 0 then 1 -> a second frame of 9 words.
REQ-037 Scenario: done drops after 5 words -> abort pulses once, m_valid=0 next cycle, state IDLE; reset asserted mid-SWEEP -> all outputs at reset values the next cycle.
REQ-038 Scenario: with MAT_RESULT_DRAIN_PARITY_EN, res_in=0x00000007 -> m_parity=1; res_in=0x00000003 -> m_parity=0.
